// File: rtl/cp0_unit_v2.sv
// CP0 privileged register block: BadVAddr/Count/Compare/Status/Cause/EPC,
// one trap or ERET per cycle at commit, and a one-cycle redirect to fetch.
module cp0_unit_v2 #(
  parameter int          N_HW_INT   = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic [N_HW_INT-1:0] ext_int,
  input  logic                commit_valid,
  input  logic [31:0]         commit_pc,
  input  logic                commit_bd,
  input  logic                exc_valid,
  input  logic [4:0]          exc_code,
  input  logic                exc_badva_we,
  input  logic [31:0]         exc_badva,
  input  logic                eret,
  input  logic                mtc0_we,
  input  logic [4:0]          mtc0_addr,
  input  logic [2:0]          mtc0_sel,
  input  logic [31:0]         mtc0_wdata,
  input  logic [4:0]          mfc0_addr,
  output logic [31:0]         mfc0_rdata,
  output logic                flush,
  output logic [31:0]         flush_target,
  output logic                int_pending,
  output logic [31:0]         status,
  output logic [31:0]         cause,
  output logic [31:0]         epc
);

  logic [7:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic        r_ti;
  logic [5:0]  r_ip_hw;
  logic [1:0]  r_ip_sw;
  logic [4:0]  r_exc_code;
  logic [31:0] r_epc;
  logic [31:0] r_badva;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic [3:0]  r_presc;
  logic        r_flush;
  logic [31:0] r_flush_target;

  logic [7:0]  w_ip;
  logic        w_take_int;
  logic        w_take_exc;
  logic        w_take_trap;
  logic        w_take_eret;
  logic        w_mtc0;
  logic        w_wr_count;
  logic        w_wr_compare;
  logic        w_presc_wrap;

  // IP[15] doubles as the timer interrupt line.
  assign w_ip        = {r_ip_hw[5] | r_ti, r_ip_hw[4:0], r_ip_sw};
  assign status      = {9'd0, 1'b1, 6'd0, r_im, 6'd0, r_exl, r_ie};
  assign cause       = {r_bd, r_ti, 14'd0, w_ip, 1'b0, r_exc_code, 2'b00};
  assign epc         = r_epc;
  assign int_pending = r_ie & ~r_exl & (|(w_ip & r_im));
  assign flush       = r_flush;
  assign flush_target = r_flush_target;

  // stall=1 blocks every commit-side update (trap, ERET, MTC0, redirect);
  // the timer, prescaler and interrupt sampling keep running regardless.
  assign w_take_int   = ~stall & commit_valid & int_pending;
  assign w_take_exc   = ~stall & commit_valid & exc_valid & ~int_pending;
  assign w_take_trap  = w_take_int | w_take_exc;
  assign w_take_eret  = ~stall & commit_valid & eret & ~int_pending & ~exc_valid;
  assign w_mtc0       = ~stall & commit_valid & mtc0_we & (mtc0_sel == 3'd0)
                        & ~int_pending & ~exc_valid & ~eret;
  assign w_wr_count   = w_mtc0 & (mtc0_addr == 5'd9);
  assign w_wr_compare = w_mtc0 & (mtc0_addr == 5'd11);
  assign w_presc_wrap = (r_presc == 4'(COUNT_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_im           <= 8'd0;
      r_exl          <= 1'b0;
      r_ie           <= 1'b0;
      r_bd           <= 1'b0;
      r_ti           <= 1'b0;
      r_ip_hw        <= 6'd0;
      r_ip_sw        <= 2'd0;
      r_exc_code     <= 5'd0;
      r_epc          <= 32'd0;
      r_badva        <= 32'd0;
      r_count        <= 32'd0;
      r_compare      <= 32'd0;
      r_presc        <= 4'd0;
      r_flush        <= 1'b0;
      r_flush_target <= 32'd0;
    end else begin
      r_ip_hw <= 6'(ext_int);

      if (w_wr_count) begin
        r_count <= mtc0_wdata;
        r_presc <= 4'd0;
      end else if (w_presc_wrap) begin
        r_count <= r_count + 32'd1;
        r_presc <= 4'd0;
      end else begin
        r_presc <= r_presc + 4'd1;
      end

      if (w_wr_compare) begin
        r_compare <= mtc0_wdata;
        r_ti      <= 1'b0;
      end else if ((r_count == r_compare) && (r_compare != 32'd0)) begin
        r_ti <= 1'b1;
      end

      r_flush <= w_take_trap | w_take_eret;

      if (w_take_trap) begin
        r_exc_code <= w_take_int ? 5'd0 : exc_code;
        // A nested trap keeps the original return point.
        if (!r_exl) begin
          r_epc <= commit_bd ? (commit_pc - 32'd4) : commit_pc;
          r_bd  <= commit_bd;
        end
        r_exl <= 1'b1;
        if (w_take_exc && exc_badva_we) r_badva <= exc_badva;
        r_flush_target <= EXC_VECTOR;
      end else if (w_take_eret) begin
        r_exl          <= 1'b0;
        r_flush_target <= r_epc;
      end else if (w_mtc0) begin
        case (mtc0_addr)
          5'd12: begin
            r_im  <= mtc0_wdata[15:8];
            r_exl <= mtc0_wdata[1];
            r_ie  <= mtc0_wdata[0];
          end
          5'd13:   r_ip_sw <= mtc0_wdata[9:8];
          5'd14:   r_epc   <= mtc0_wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    mfc0_rdata = 32'd0;
    case (mfc0_addr)
      5'd8:    mfc0_rdata = r_badva;
      5'd9:    mfc0_rdata = r_count;
      5'd11:   mfc0_rdata = r_compare;
      5'd12:   mfc0_rdata = status;
      5'd13:   mfc0_rdata = cause;
      5'd14:   mfc0_rdata = r_epc;
      default: mfc0_rdata = 32'd0;
    endcase
  end

endmodule

// File: doc/cp0_unit_v2.md
Name: cp0_unit_v2

Overview:
- Parametrised successor of the CP0 privileged register block. Sits beside the writeback/commit stage of the pipeline.
- Holds BadVAddr, Count, Compare, Status, Cause and EPC.
- Arbitrates one committed exception or interrupt per cycle, handles ERET, and issues a one-cycle redirect (flush plus target) to the fetch stage.
- Adds over the previous generation: a working Count/Compare timer interrupt, a configurable hardware-interrupt width, a Count prescaler, a configurable exception vector, and a clean stall handshake.

Parameters:
- N_HW_INT, 6, number of external hardware interrupt lines (1..6), mapped to Cause.IP[2+N_HW_INT-1:2].
- COUNT_DIV, 2, Count increments once every COUNT_DIV clocks (1..16).
- EXC_VECTOR, 32'hBFC00380, redirect target on exception or interrupt.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low.
- stall  in  1  freezes architectural updates this cycle.
- ext_int  in  N_HW_INT  level-sensitive hardware interrupts.
- commit_valid  in  1  an instruction is committing this cycle.
- commit_pc  in  32  PC of the committing instruction.
- commit_bd  in  1  committing instruction is in a branch delay slot.
- exc_valid  in  1  committing instruction raised an exception.
- exc_code  in  5  ExcCode of that exception.
- exc_badva_we  in  1  exception carries a bad virtual address.
- exc_badva  in  32  the bad virtual address.
- eret  in  1  committing instruction is ERET.
- mtc0_we  in  1  MTC0 commit.
- mtc0_addr  in  5  MTC0 target register number.
- mtc0_sel  in  3  MTC0 select field.
- mtc0_wdata  in  32  MTC0 write data.
- mfc0_addr  in  5  read address.
- mfc0_rdata  out  32  read data (combinational).
- flush  out  1  one-cycle redirect pulse.
- flush_target  out  32  redirect PC, valid when flush=1.
- int_pending  out  1  an enabled, unmasked interrupt exists.
- status  out  32  Status register.
- cause  out  32  Cause register.
- epc  out  32  EPC register.

Behaviour:
- Reset (rst=0 at a clk edge): Status=32'h00400000 (BEV=1, all else 0); Cause=0; EPC=0; BadVAddr=0; Count=0; Compare=0; prescaler=0; flush=0; flush_target=0.
- Status fields:
  - Writable: IM[15:8], EXL[1], IE[0].
  - BEV[22] reads constant 1.
  - All other bits read 0.
- Cause fields:
  - BD[31]: updated on exception or interrupt.
  - TI[30]: timer interrupt flag.
  - IP[15:10]: registered ext_int each cycle. Unused upper bits are 0. IP[15] is ORed with TI.
  - IP[9:8]: software interrupts, MTC0-writable.
  - ExcCode[6:2].
  - All other bits 0.
- int_pending = IE & ~EXL & |(Cause.IP[15:8] & Status.IM[15:8]). Computed combinationally from registered values.
- Priority at each clk edge when stall=0 (first match wins):
  1. Interrupt: int_pending & commit_valid.
  2. Exception: exc_valid & commit_valid.
  3. ERET: eret & commit_valid.
  4. MTC0: mtc0_we & commit_valid & mtc0_sel==0.
- Interrupt or exception taken:
  - ExcCode = 0 for an interrupt, otherwise exc_code.
  - If EXL was 0: EPC = commit_bd ? commit_pc-4 : commit_pc, and BD = commit_bd.
  - If EXL was 1: EPC and BD are unchanged.
  - EXL <= 1.
  - BadVAddr <= exc_badva only for an exception with exc_badva_we=1.
  - flush=1 and flush_target=EXC_VECTOR next cycle.
- ERET: EXL <= 0; flush=1 and flush_target=EPC (value before this edge) next cycle.
- MTC0 targets:
  - 9 → Count; also resets the prescaler.
  - 11 → Compare; also clears TI.
  - 12 → Status writable fields.
  - 13 → IP[9:8].
  - 14 → EPC.
  - Any other address, or sel≠0: write ignored.
- Timer:
  - Prescaler counts 0..COUNT_DIV-1. When it wraps, Count <= Count+1, modulo 2^32 (0xFFFFFFFF → 0).
  - TI is set when registered Count==Compare and Compare≠0. TI is sticky until Compare is written.
  - Same-cycle conflicts: an MTC0 Count write beats the increment; an MTC0 Compare write beats setting TI.
- stall=1:
  - Status, Cause.BD, Cause.ExcCode, EPC, BadVAddr and flush are frozen (flush forced 0).
  - Cause.IP sampling, Count, the prescaler and TI continue.
- flush is never asserted on two consecutive cycles from a single event.
- mfc0_rdata:
  - Addresses 8, 9, 11, 12, 13, 14 return BadVAddr, Count, Compare, Status, Cause, EPC.
  - Any other address returns 0.
  - Reads reflect pre-edge values; there is no bypass of same-cycle MTC0.
- Reset asserted mid-redirect: flush drops to 0 at that edge.

Test Plan:
- Reset, then check defaults: mfc0 addresses 12/13/14/9 → 32'h00400000, 0, 0, 0. With COUNT_DIV=2, after 10 clocks Count=5.
- exc_valid with exc_code=5'd4, commit_pc=32'h80001008, commit_bd=1, exc_badva_we=1, exc_badva=32'h80002003:
  - next cycle: EPC=32'h80001004, BD=1, ExcCode=4, BadVAddr=32'h80002003, EXL=1;
  - flush=1 for exactly one cycle with flush_target=32'hBFC00380.
- Timer:
  - MTC0 Status=32'h00008001, Compare=20, Count=15 → TI and IP[15] set once Count reaches 20, and int_pending=1.
  - Next commit with commit_pc=32'h80000100 → ExcCode=0, EPC=32'h80000100.
  - MTC0 Compare → TI clears.
- Nested exception: second exc_valid while EXL=1 → EPC unchanged, ExcCode updated, flush asserted.
- Interrupt and exception in the same cycle: interrupt wins (ExcCode=0). Then ERET → EXL=0, flush_target=EPC.
- Stall held 3 cycles during exc_valid → no state change and no flush. After stall drops, the exception is taken once. Count advanced during the stall.
